// File: rtl/uart_slot_echo_master.sv
// Slot-bus initiator for the UART core: programs and verifies the baud divisor, then echoes
// every received byte back to TX (optionally upper-cased) one bus access per cycle.
module uart_slot_echo_master #(
  parameter int unsigned DVSR   = 650,
  parameter bit          UPCASE = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             cs,
  output logic             read,
  output logic             write,
  output logic [4:0]       addr,
  output logic [31:0]      wr_data,
  input  logic [31:0]      rd_data,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             cfg_err,
  output logic             busy
);

  localparam logic [10:0] DvsrBits = DVSR[10:0];

  typedef enum logic [2:0] {
    StCfgWr,
    StCfgRd,
    StIdle,
    StPollRx,
    StPop,
    StPollTx,
    StSend
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;
  // Holds the bus quiet until the first clock edge after reset release, so the CFG_WR access
  // starts cleanly on that edge instead of mid-cycle at the asynchronous deassertion.
  logic             started_q;

  logic unused_rd_data;
  assign unused_rd_data = ^rd_data[31:21];

  function automatic logic [7:0] xform(input logic [7:0] b);
    if (UPCASE && (b >= 8'h61) && (b <= 8'h7a)) begin
      return b - 8'h20;
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StCfgWr;
      data_q    <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_err_q;
    if (started_q) begin
      unique case (state_q)
        StCfgWr: state_d = StCfgRd;
        StCfgRd: begin
          if (rd_data[20:10] == DvsrBits) begin
            state_d = StIdle;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = StCfgWr;
          end
        end
        StIdle: begin
          if (en) state_d = StPollRx;
        end
        StPollRx: begin
          if (!rd_data[8]) begin
            data_d  = xform(rd_data[7:0]);
            state_d = StPop;
          end else if (!en) begin
            state_d = StIdle;
          end
        end
        StPop: state_d = StPollTx;
        StPollTx: begin
          if (!rd_data[9]) state_d = StSend;
        end
        StSend: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en ? StPollRx : StIdle;
        end
        default: state_d = StCfgWr;
      endcase
    end
  end

  // Bus outputs depend only on registered state, never on rd_data.
  always_comb begin
    cs      = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = 5'd0;
    wr_data = 32'd0;
    if (started_q) begin
      unique case (state_q)
        StCfgWr: begin
          cs      = 1'b1;
          write   = 1'b1;
          addr    = 5'd1;
          wr_data = {21'd0, DvsrBits};
        end
        StCfgRd, StPollRx, StPollTx: begin
          cs   = 1'b1;
          read = 1'b1;
        end
        StPop: begin
          cs    = 1'b1;
          write = 1'b1;
          addr  = 5'd3;
        end
        StSend: begin
          cs      = 1'b1;
          write   = 1'b1;
          addr    = 5'd2;
          wr_data = {24'd0, data_q};
        end
        default: ;
      endcase
    end
  end

  assign byte_cnt = cnt_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = (state_q != StIdle);

endmodule
